vector_mask_packer: RTL and testbench
=====================================

VECTOR_MASK_PACKER -- requirements
Module: vector_mask_packer

Interface
REQ-001 SHALL have parameter VLEN, default 4096, vector register width in bits.
REQ-002 SHALL have parameter ELEN, default 32, maximum supported SEW in bits.
REQ-003 SHALL have parameter LANES, default 32, elements packed per cycle; must be a power of two dividing VLEN/32.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port cmp_valid  input  1  compare result available.
REQ-007 SHALL have port cmp_ready  output  1  packer can accept a new result.
REQ-008 SHALL have port compare_result  input  VLEN  per-element compare flags, element i flag at bit i*SEW.
REQ-009 SHALL have port sew  input  2  00:8, 01:16, 10:32, 11:64 (unsupported).
REQ-010 SHALL have port vl  input  $clog2(VLEN)+1  active element count.
REQ-011 SHALL have port vstart  input  $clog2(VLEN)  first element to write.
REQ-012 SHALL have port vm  input  1  1 = unmasked, 0 = masked by v0.
REQ-013 SHALL have port v0_mask  input  VLEN  mask register v0.
REQ-014 SHALL have port vd_old  input  VLEN  prior destination contents.
REQ-015 SHALL have port mask_result  output  VLEN  packed destination mask.
REQ-016 SHALL have port mask_valid  output  1  mask_result valid.
REQ-017 SHALL have port mask_ready  input  1  consumer accepts mask_result.
REQ-018 SHALL have port sew_err  output  1  latched request had sew=11.

Function
REQ-019 SHALL implement states IDLE, PACK, DONE; cmp_ready=1 only in IDLE.
REQ-020 SHALL, on cmp_valid&&cmp_ready, latch all request inputs, set element index to 0, clear sew_err.
REQ-021 SHALL on accept set result register to all ones above vl (tail-policy bits per REQ-032) and vd_old below vl.
REQ-022 SHALL go IDLE->DONE directly with mask_result=vd_old when vl==0, vstart>=vl, or sew==11 (sew_err=1 for the latter); else IDLE->PACK.
REQ-023 SHALL limit effective vl to VLMAX=VLEN/SEW; bits from VLMAX upward are tail.
REQ-024 SHALL in PACK process elements idx..idx+LANES-1 each cycle, then idx+=LANES.
REQ-025 SHALL per element e<vl: e<vstart -> vd_old[e]; vm==0&&v0_mask[e]==0 -> vd_old[e]; else compare_result[e*SEW].
REQ-026 SHALL leave PACK for DONE after the cycle where idx+LANES>=vl; PACK lasts ceil(vl/LANES) cycles.
REQ-027 SHALL assert mask_valid in DONE, holding mask_result stable until mask_ready; handshake returns to IDLE.
REQ-028 SHALL give accept-to-mask_valid latency of 1+ceil(vl/LANES) cycles (1 for the REQ-022 bypass).
REQ-029 SHALL ignore cmp_valid outside IDLE; input changes after accept do not affect the result.

Reset
REQ-030 SHALL, when reset==0 at a clock edge, force IDLE, mask_result=0, mask_valid=0, sew_err=0, index=0, including mid-PACK or mid-DONE (in-flight result discarded).
REQ-031 SHALL drive cmp_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-032 SHALL with VMASK_TAIL_AGNOSTIC_EN defined write tail bits (e>=vl) as 1; without it, tail bits SHALL equal vd_old (undisturbed).

Structure
REQ-033 SHALL take the sew encoding enum and packer state enum from the shared vector_processor_pkg.
REQ-034 SHALL instantiate one sub-module vmask_elem_extract: given compare_result, sew, base index, returns LANES flag bits.

Verification
REQ-035 SHALL cover sew=10, vl=8, vm=1, vstart=0, flags alternating 1,0 -> mask_result[7:0]=0x55, valid after 2 cycles.
REQ-036 SHALL cover sew=00, vl=100, LANES=32, vstart=4, vd_old=all ones, flags 0 -> bits[3:0]=1, [99:4]=0, valid after 5 cycles.
REQ-037 SHALL cover vm=0, v0_mask=0x0F, vd_old=0, all flags 1, vl=8, sew=01 -> mask_result[7:0]=0x0F.
REQ-038 SHALL cover tail: vl=5, vd_old=0 -> bits[VLEN-1:5] all 1 with VMASK_TAIL_AGNOSTIC_EN, all 0 without.
REQ-039 SHALL cover vl=0 and sew=11 -> mask_result=vd_old after 1 cycle; sew_err=1 only for sew=11.
REQ-040 SHALL cover reset asserted in PACK and mask_ready held low for 10 cycles in DONE -> IDLE with zeroed outputs; mask_result stable while stalled.

Source files
------------

// File: rtl/vector_processor_pkg.sv
// Shared vector-processor types used by the mask packer and its helpers.
//
// Contents:
//   sew_e        - element-width encoding (00:8, 01:16, 10:32, 11:64)
//   pack_state_e - mask packer FSM states
//   sew_log2     - log2(SEW/8), the stride shift that turns an element index
//                  into a bit position (index << sew_log2 << 3)
package vector_processor_pkg;

   typedef enum logic [1:0] {
      Sew8  = 2'b00,
      Sew16 = 2'b01,
      Sew32 = 2'b10,
      Sew64 = 2'b11
   } sew_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StPack = 2'd1,
      StDone = 2'd2
   } pack_state_e;

   function automatic logic [1:0] sew_log2(input sew_e s);
      return s;
   endfunction

endpackage

// File: rtl/vmask_elem_extract.sv
// Extracts one flag per element for a LANES-wide window of elements.
//
// Ports:
//   compare_result - per-element compare flags, element i flag at bit i*SEW
//   sew            - element width encoding
//   base           - index of the first element in the window
//   flags          - flags[j] is the flag of element base+j (0 past the vector)
module vmask_elem_extract
   import vector_processor_pkg::*;
#(
   parameter int unsigned VLEN  = 4096,
   parameter int unsigned LANES = 32
) (
   input  logic [VLEN-1:0]       compare_result,
   input  sew_e                  sew,
   input  logic [$clog2(VLEN):0] base,
   output logic [LANES-1:0]      flags
);

   localparam int unsigned AW = $clog2(VLEN);
   // Wide enough for (base + LANES) * 64 without wrapping.
   localparam int unsigned PW = AW + 8;

   always_comb begin
      logic [PW-1:0] pos;
      pos   = '0;
      flags = '0;
      for (int unsigned j = 0; j < LANES; j++) begin
         pos = (PW'(base) + PW'(j)) << (PW'(sew_log2(sew)) + PW'(3));
         if (pos < PW'(VLEN)) begin
            flags[j] = compare_result[pos[AW-1:0]];
         end
      end
   end

endmodule

// File: rtl/vector_mask_packer.sv
// Packs SEW-strided vector compare results into a one-bit-per-element mask.
//
// A request is latched when cmp_valid && cmp_ready. The result register is
// seeded from vd_old, then LANES elements per cycle are overwritten with their
// compare flag (honouring vstart and the v0 mask when vm==0). The finished mask
// is offered with mask_valid/mask_ready.
//
// Ports:
//   clk, reset          - clock, synchronous active-low reset
//   cmp_valid/cmp_ready - request handshake (ready only when idle)
//   compare_result      - compare flags, element i at bit i*SEW
//   sew, vl, vstart, vm - element width, active length, start element, unmasked
//   v0_mask, vd_old     - mask register and prior destination contents
//   mask_result         - packed destination mask
//   mask_valid/ready    - result handshake
//   sew_err             - latched request used an unsupported SEW
//
// Configuration:
//   VMASK_TAIL_AGNOSTIC_EN - when defined, tail bits (e >= effective vl) are
//                            written as 1; otherwise they keep vd_old.
module vector_mask_packer
   import vector_processor_pkg::*;
#(
   parameter int unsigned VLEN  = 4096,
   parameter int unsigned ELEN  = 32,
   parameter int unsigned LANES = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmp_valid,
   output logic                    cmp_ready,
   input  logic [VLEN-1:0]         compare_result,
   input  logic [1:0]              sew,
   input  logic [$clog2(VLEN):0]   vl,
   input  logic [$clog2(VLEN)-1:0] vstart,
   input  logic                    vm,
   input  logic [VLEN-1:0]         v0_mask,
   input  logic [VLEN-1:0]         vd_old,
   output logic [VLEN-1:0]         mask_result,
   output logic                    mask_valid,
   input  logic                    mask_ready,
   output logic                    sew_err
);

   localparam int unsigned AW = $clog2(VLEN);
   localparam int unsigned IW = AW + 1;
   localparam logic [IW-1:0] VlmaxSew8 = IW'(VLEN / 8);
   localparam logic [IW:0]   LanesW    = (IW + 1)'(LANES);

   pack_state_e     state_q, state_d;
   logic [VLEN-1:0] result_q, result_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            sew_err_q, sew_err_d;

   // Latched request
   logic [VLEN-1:0] cmp_q;
   logic [VLEN-1:0] v0_q;
   logic            vm_q;
   sew_e            sew_q;
   logic [IW-1:0]   vl_q;
   logic [IW-1:0]   vstart_q;

   logic            accept;
   logic            sew_bad;
   logic [IW-1:0]   vlmax_in;
   logic [IW-1:0]   vl_eff_in;
   logic            bypass;
   logic [VLEN-1:0] result_init;
   logic [LANES-1:0] lane_flags;

   assign accept  = cmp_valid && (state_q == StIdle);
   assign sew_bad = (sew == 2'b11) || ((32'd8 << sew) > ELEN);

   // VLMAX = VLEN/SEW; vl beyond it is clipped so those elements become tail.
   assign vlmax_in  = VlmaxSew8 >> sew;
   assign vl_eff_in = (vl > vlmax_in) ? vlmax_in : vl;
   assign bypass    = sew_bad || (vl_eff_in == '0) || ({1'b0, vstart} >= vl_eff_in);

`ifdef VMASK_TAIL_AGNOSTIC_EN
   assign result_init = vd_old | ({VLEN{1'b1}} << vl_eff_in);
`else
   assign result_init = vd_old;
`endif

   vmask_elem_extract #(
      .VLEN  (VLEN),
      .LANES (LANES)
   ) u_extract (
      .compare_result (cmp_q),
      .sew            (sew_q),
      .base           (idx_q),
      .flags          (lane_flags)
   );

   always_comb begin
      logic [IW-1:0] elem;
      elem      = '0;
      state_d   = state_q;
      idx_d     = idx_q;
      result_d  = result_q;
      sew_err_d = sew_err_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               idx_d     = '0;
               sew_err_d = sew_bad;
               if (bypass) begin
                  result_d = vd_old;
                  state_d  = StDone;
               end else begin
                  result_d = result_init;
                  state_d  = StPack;
               end
            end
         end
         StPack: begin
            // Elements below vstart or masked off are left at their vd_old seed.
            for (int unsigned j = 0; j < LANES; j++) begin
               elem = idx_q + IW'(j);
               if ((elem < vl_q) && (elem >= vstart_q) &&
                   (vm_q || v0_q[elem[AW-1:0]])) begin
                  result_d[elem[AW-1:0]] = lane_flags[j];
               end
            end
            idx_d = idx_q + IW'(LANES);
            if (({1'b0, idx_q} + LanesW) >= {1'b0, vl_q}) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (mask_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StIdle;
         result_q  <= '0;
         idx_q     <= '0;
         sew_err_q <= 1'b0;
         cmp_q     <= '0;
         v0_q      <= '0;
         vm_q      <= 1'b0;
         sew_q     <= Sew8;
         vl_q      <= '0;
         vstart_q  <= '0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         idx_q     <= idx_d;
         sew_err_q <= sew_err_d;
         if (accept) begin
            cmp_q    <= compare_result;
            v0_q     <= v0_mask;
            vm_q     <= vm;
            sew_q    <= sew_e'(sew);
            vl_q     <= vl_eff_in;
            vstart_q <= {1'b0, vstart};
         end
      end
   end

   assign cmp_ready   = (state_q == StIdle);
   assign mask_valid  = (state_q == StDone);
   assign mask_result = result_q;
   assign sew_err     = sew_err_q;

endmodule

// File: tb/tb_vector_mask_packer.sv
// Self-checking bench for vector_mask_packer: directed scenarios plus random
// requests compared against an element-by-element reference model.
module tb_vector_mask_packer;

   localparam int unsigned VLEN  = 4096;
   localparam int unsigned ELEN  = 32;
   localparam int unsigned LANES = 32;
   localparam int unsigned AW    = $clog2(VLEN);
   localparam int unsigned IW    = AW + 1;
`ifdef VMASK_TAIL_AGNOSTIC_EN
   localparam bit AGN = 1'b1;
`else
   localparam bit AGN = 1'b0;
`endif

   logic            clk;
   logic            reset;
   logic            cmp_valid;
   logic            cmp_ready;
   logic [VLEN-1:0] compare_result;
   logic [1:0]      sew;
   logic [IW-1:0]   vl;
   logic [AW-1:0]   vstart;
   logic            vm;
   logic [VLEN-1:0] v0_mask;
   logic [VLEN-1:0] vd_old;
   logic [VLEN-1:0] mask_result;
   logic            mask_valid;
   logic            mask_ready;
   logic            sew_err;

   int checks = 0;
   int errors = 0;

   // Request under test and its expected outcome
   logic [VLEN-1:0] t_cr, t_v0, t_vd;
   int              t_sew, t_vl, t_vstart;
   bit              t_vm;
   logic [VLEN-1:0] exp_mask;
   int              exp_lat;
   bit              exp_err;

   vector_mask_packer #(
      .VLEN  (VLEN),
      .ELEN  (ELEN),
      .LANES (LANES)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .cmp_valid      (cmp_valid),
      .cmp_ready      (cmp_ready),
      .compare_result (compare_result),
      .sew            (sew),
      .vl             (vl),
      .vstart         (vstart),
      .vm             (vm),
      .v0_mask        (v0_mask),
      .vd_old         (vd_old),
      .mask_result    (mask_result),
      .mask_valid     (mask_valid),
      .mask_ready     (mask_ready),
      .sew_err        (sew_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [VLEN-1:0] rand_vec();
      logic [VLEN-1:0] v;
      for (int w = 0; w < VLEN / 32; w++) v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic int first_diff(input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
      for (int i = 0; i < VLEN; i++) if (a[i] !== b[i]) return i;
      return -1;
   endfunction

   // Reference: mask semantics straight from the element rules.
   task automatic model();
      int sew_b, vlmax, vle;
      sew_b   = 8 << t_sew;
      vlmax   = VLEN / sew_b;
      vle     = (t_vl > vlmax) ? vlmax : t_vl;
      exp_err = (sew_b > ELEN);
      if (exp_err || vle == 0 || t_vstart >= vle) begin
         exp_mask = t_vd;
         exp_lat  = 1;
         return;
      end
      exp_lat = 1 + (vle + LANES - 1) / LANES;
      for (int e = 0; e < VLEN; e++) begin
         if (e >= vle) exp_mask[e] = AGN ? 1'b1 : t_vd[e];
         else if (e < t_vstart || (!t_vm && !t_v0[e])) exp_mask[e] = t_vd[e];
         else exp_mask[e] = t_cr[e * sew_b];
      end
   endtask

   // Issue t_* as one request; stall the result ready_delay cycles before taking it.
   task automatic run_txn(input string name, input int ready_delay, input bit junk);
      int lat;
      int d;
      model();
      checks++;
      if (cmp_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s cmp_ready before accept got %b want 1", name, cmp_ready);
      end
      compare_result = t_cr;
      v0_mask        = t_v0;
      vd_old         = t_vd;
      sew            = 2'(t_sew);
      vl             = IW'(t_vl);
      vstart         = AW'(t_vstart);
      vm             = t_vm;
      cmp_valid      = 1'b1;
      @(posedge clk);
      #1;
      // Everything after accept must be ignored.
      cmp_valid      = junk;
      compare_result = rand_vec();
      v0_mask        = rand_vec();
      vd_old         = rand_vec();
      vl             = IW'($urandom_range(0, VLEN));
      vm             = ~t_vm;
      lat = 1;
      while (!mask_valid && lat < 1000) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (!mask_valid) begin
         errors++;
         $display("FAIL %s mask_valid timeout got 0 want 1", name);
         cmp_valid = 1'b0;
         return;
      end
      if (lat !== exp_lat) begin
         errors++;
         $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
      end
      checks++;
      if (mask_result !== exp_mask) begin
         errors++;
         d = first_diff(mask_result, exp_mask);
         $display("FAIL %s mask_result bit %0d got %b want %b", name, d, mask_result[d],
                  exp_mask[d]);
      end
      checks++;
      if (sew_err !== exp_err) begin
         errors++;
         $display("FAIL %s sew_err got %b want %b", name, sew_err, exp_err);
      end
      for (int k = 0; k < ready_delay; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (mask_valid !== 1'b1 || mask_result !== exp_mask) begin
            errors++;
            $display("FAIL %s stall cycle %0d valid got %b want 1 result_ok got %b want 1",
                     name, k, mask_valid, (mask_result === exp_mask));
         end
      end
      mask_ready = 1'b1;
      cmp_valid  = 1'b0;
      @(posedge clk);
      #1;
      mask_ready = 1'b0;
      checks++;
      if (mask_valid !== 1'b0 || cmp_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s after handshake valid got %b want 0 ready got %b want 1", name,
                  mask_valid, cmp_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (mask_valid !== 1'b0 || sew_err !== 1'b0) begin
         errors++;
         $display("FAIL reset valid got %b want 0 sew_err got %b want 0", mask_valid, sew_err);
      end
      checks++;
      if (mask_result !== '0) begin
         errors++;
         $display("FAIL reset mask_result bit %0d got 1 want 0", first_diff(mask_result, '0));
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (cmp_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset cmp_ready got %b want 1", cmp_ready);
      end
   endtask

   task automatic test_directed();
      // sew=32, alternating flags
      t_cr = '0;
      for (int i = 0; i < 8; i += 2) t_cr[i * 32] = 1'b1;
      t_v0 = '0; t_vd = '0; t_sew = 2; t_vl = 8; t_vstart = 0; t_vm = 1'b1;
      run_txn("alt_sew32", 0, 1'b0);
      checks++;
      if (mask_result[7:0] !== 8'h55) begin
         errors++;
         $display("FAIL alt_sew32 low byte got %h want 55", mask_result[7:0]);
      end
      // vstart=4 over all-ones vd_old, flags zero
      t_cr = '0; t_vd = '1; t_sew = 0; t_vl = 100; t_vstart = 4; t_vm = 1'b1;
      run_txn("vstart4", 0, 1'b0);
      checks++;
      if (mask_result[3:0] !== 4'hF || mask_result[99:4] !== '0) begin
         errors++;
         $display("FAIL vstart4 slices got %h/%0d want f/0", mask_result[3:0],
                  first_diff(mask_result[99:0], {96'd0, 4'hF}));
      end
      // v0 masking
      t_cr = '1; t_v0 = '0; t_v0[7:0] = 8'h0F; t_vd = '0; t_sew = 1; t_vl = 8;
      t_vstart = 0; t_vm = 1'b0;
      run_txn("v0mask", 0, 1'b0);
      checks++;
      if (mask_result[7:0] !== 8'h0F) begin
         errors++;
         $display("FAIL v0mask low byte got %h want 0f", mask_result[7:0]);
      end
      // tail policy
      t_cr = rand_vec(); t_vd = '0; t_sew = 0; t_vl = 5; t_vstart = 0; t_vm = 1'b1;
      run_txn("tail", 0, 1'b0);
      checks++;
      if (mask_result[VLEN-1:5] !== (AGN ? {(VLEN-5){1'b1}} : {(VLEN-5){1'b0}})) begin
         errors++;
         $display("FAIL tail bit5 got %b want %b", mask_result[5], AGN);
      end
      // vl above VLMAX clips to VLMAX
      t_cr = rand_vec(); t_vd = rand_vec(); t_sew = 2; t_vl = 200; t_vstart = 3;
      run_txn("vl_over_vlmax", 0, 1'b0);
      // bypasses
      t_vd = rand_vec(); t_sew = 0; t_vl = 0; t_vstart = 0;
      run_txn("vl_zero", 0, 1'b0);
      t_vd = rand_vec(); t_sew = 3; t_vl = 10;
      run_txn("sew64", 0, 1'b0);
      t_vd = rand_vec(); t_sew = 1; t_vl = 20; t_vstart = 20;
      run_txn("vstart_ge_vl", 0, 1'b0);
   endtask

   task automatic test_stall();
      t_cr = rand_vec(); t_v0 = rand_vec(); t_vd = rand_vec();
      t_sew = 0; t_vl = 70; t_vstart = 1; t_vm = 1'b0;
      run_txn("stall10", 10, 1'b1);
   endtask

   task automatic test_reset_mid();
      // Reset while packing
      compare_result = rand_vec(); vd_old = rand_vec(); v0_mask = '0;
      sew = 2'b00; vl = IW'(200); vstart = '0; vm = 1'b1; cmp_valid = 1'b1;
      @(posedge clk);
      #1;
      cmp_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (mask_valid !== 1'b0 || cmp_ready !== 1'b1 || mask_result !== '0) begin
         errors++;
         $display("FAIL reset_in_pack valid got %b want 0 ready got %b want 1 zero got %b want 1",
                  mask_valid, cmp_ready, (mask_result === '0));
      end
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (mask_valid !== 1'b0 || cmp_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_pack after valid got %b want 0 ready got %b want 1",
                  mask_valid, cmp_ready);
      end
      // Reset while holding a result
      vd_old = rand_vec(); sew = 2'b11; vl = IW'(10); cmp_valid = 1'b1;
      @(posedge clk);
      #1;
      cmp_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (mask_valid !== 1'b1 || sew_err !== 1'b1) begin
         errors++;
         $display("FAIL done_before_reset valid got %b want 1 sew_err got %b want 1",
                  mask_valid, sew_err);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (mask_valid !== 1'b0 || sew_err !== 1'b0 || mask_result !== '0) begin
         errors++;
         $display("FAIL reset_in_done valid got %b want 0 sew_err got %b want 0 zero got %b want 1",
                  mask_valid, sew_err, (mask_result === '0));
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         t_sew    = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
         t_vl     = $urandom_range(0, ((VLEN / 8) >> t_sew) + 40);
         t_vstart = $urandom_range(0, t_vl + 3);
         if (t_vstart > VLEN - 1) t_vstart = VLEN - 1;
         t_vm     = 1'($urandom_range(0, 1));
         t_cr     = rand_vec();
         t_v0     = rand_vec();
         t_vd     = rand_vec();
         run_txn($sformatf("random%0d", n), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      reset = 1'b0; cmp_valid = 1'b0; mask_ready = 1'b0;
      compare_result = '0; sew = '0; vl = '0; vstart = '0; vm = 1'b1;
      v0_mask = '0; vd_old = '0;
      test_reset();
      test_directed();
      test_stall();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
